test_pattern_gen: RTL and testbench
===================================

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 SHALL have parameter COLOR_W, default 8: bits per colour channel (4..12).
REQ-002 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-004 SHALL have parameter CHECK_LOG2, default 3: log2 of checker square size in pixels.
REQ-005 SHALL have port vga_clk  input  1  pixel clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port fb_hblank  input  1  horizontal blanking, high outside active line.
REQ-008 SHALL have port fb_vblank  input  1  vertical blanking, high outside active frame.
REQ-009 SHALL have port mode  input  2  pattern select: 0 gradient, 1 colour bars, 2 checker, 3 solid.
REQ-010 SHALL have port solid_rgb  input  3*COLOR_W  solid colour {R,G,B}, used in mode 3.
REQ-011 SHALL have ports red, green, blue  output  COLOR_W each  registered pixel colour.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse on first active pixel of each frame.
REQ-013 SHALL have port frame_cnt  output  16  completed-frame count, wraps 0xFFFF->0.
REQ-014 SHALL have port fmt_err  output  1  sticky: active region exceeded H_ACTIVE or V_ACTIVE.

Function
REQ-015 SHALL treat blank inputs as synchronous data only; no input other than reset_n SHALL act asynchronously.
REQ-016 SHALL define active = ~fb_hblank & ~fb_vblank, sampled each vga_clk edge.
REQ-017 SHALL keep pixel counter x (clog2(H_ACTIVE) bits): +1 per active cycle, cleared when fb_hblank is high.
REQ-018 SHALL keep line counter y (clog2(V_ACTIVE) bits): +1 on each fb_hblank rising edge while fb_vblank low, cleared when fb_vblank is high.
REQ-019 SHALL saturate x at H_ACTIVE-1 and y at V_ACTIVE-1; an active cycle with x = H_ACTIVE-1 already used, or a line start with y = V_ACTIVE-1 already used, SHALL set fmt_err.
REQ-020 SHALL latch mode and solid_rgb into active_mode/active_rgb on the fb_vblank rising edge only; changes mid-frame SHALL NOT affect the current frame.
REQ-021 SHALL increment frame_cnt on each fb_vblank rising edge.
REQ-022 SHALL pulse frame_start for exactly one cycle, aligned with the output colour of pixel (0,0).
REQ-023 SHALL register outputs with latency 1: colour for the pixel active at edge N appears after edge N+1.
REQ-024 SHALL drive red/green/blue = 0 for any cycle whose sampled active was 0.
REQ-025 Mode 0 SHALL output red = y mod 2^COLOR_W, green = x mod 2^COLOR_W, blue = (x+y) mod 2^COLOR_W.
REQ-026 Mode 1 SHALL split the line into 8 bars, bar k covering x in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8) (integer division, thresholds as constants); last bar extends to H_ACTIVE-1.
REQ-027 Mode 1 bar colours SHALL be, in order k=0..7: white, yellow, cyan, green, magenta, red, blue, black; "on" channel = all ones, "off" = 0.
REQ-028 Mode 2 SHALL output all ones on all channels when bit CHECK_LOG2 of x XOR bit CHECK_LOG2 of y is 0, else all zeros.
REQ-029 Mode 3 SHALL output active_rgb unchanged.
REQ-030 SHALL NOT require a divider or multiplier at runtime; all bar thresholds SHALL be elaboration-time constants.

Reset
REQ-031 On reset_n low SHALL asynchronously clear red, green, blue, x, y, frame_cnt, frame_start, fmt_err, active_mode (=0), active_rgb (=0) and all edge-detect history.
REQ-032 After reset release SHALL output zero colour until the first fb_vblank rising edge latches a mode; until then mode 0 (gradient) SHALL apply.
REQ-033 Reset asserted mid-line SHALL abort the line; on release x and y restart from 0 at the next blank.

Verification
REQ-034 Mode 0, COLOR_W=8, 640x480 timing: pixel (300,10) -> red=10, green=44, blue=54 one cycle after that pixel is active.
REQ-035 Mode 1, H_ACTIVE=640: x=79 -> white (FF,FF,FF); x=80 -> yellow (FF,FF,00); x=639 -> black (00,00,00).
REQ-036 Mode 2, CHECK_LOG2=3: (0,0) -> all FF; (8,0) -> all 00; (8,8) -> all FF.
REQ-037 Drive mode 0->3 mid-frame with solid_rgb=0x123456: current frame stays gradient; next frame outputs 12/34/56 on every active pixel; frame_cnt increments by 1 per vblank.
REQ-038 Apply 641 active pixels on one line -> x holds 639, fmt_err rises and stays 1 until reset_n low, which clears it and all outputs to 0.
REQ-039 Blank cycles in every mode -> red/green/blue = 0; frame_start high for exactly one cycle per frame.

Source files
------------

// File: rtl/test_pattern_gen_if.sv
// Video timing inputs and pixel outputs of the test pattern generator.
// The master drives the blanking and pattern selection and receives the pixels.
interface test_pattern_gen_if #(
  parameter int COLOR_W = 8
);
  logic                   fb_hblank;
  logic                   fb_vblank;
  logic [1:0]             mode;
  logic [3*COLOR_W-1:0]   solid_rgb;
  logic [COLOR_W-1:0]     red;
  logic [COLOR_W-1:0]     green;
  logic [COLOR_W-1:0]     blue;
  logic                   frame_start;
  logic [15:0]            frame_cnt;
  logic                   fmt_err;

  modport master (
    output fb_hblank, fb_vblank, mode, solid_rgb,
    input  red, green, blue, frame_start, frame_cnt, fmt_err
  );

  modport slave (
    input  fb_hblank, fb_vblank, mode, solid_rgb,
    output red, green, blue, frame_start, frame_cnt, fmt_err
  );
endinterface

// File: rtl/test_pattern_gen.sv
// Test pattern generator: gradient, colour bars, checkerboard or solid colour,
// one registered pixel per vga_clk, following external blanking signals.
module test_pattern_gen #(
  parameter int COLOR_W    = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CHECK_LOG2 = 3
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  test_pattern_gen_if.slave vid
);
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);
  localparam int unsigned BAR_T [8] = '{
    0, H_ACTIVE/8, 2*H_ACTIVE/8, 3*H_ACTIVE/8,
    4*H_ACTIVE/8, 5*H_ACTIVE/8, 6*H_ACTIVE/8, 7*H_ACTIVE/8
  };

  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic                   x_full;
  logic                   y_full;
  logic                   hblank_d;
  logic                   vblank_d;
  logic                   armed;
  logic [1:0]             active_mode;
  logic [3*COLOR_W-1:0]   active_rgb;
  logic [3*COLOR_W-1:0]   pix;
  logic [31:0]            xw;
  logic [31:0]            yw;
  logic [2:0]             bar;

  logic active;
  logic hblank_rise;
  logic vblank_rise;

  assign active      = ~vid.fb_hblank & ~vid.fb_vblank;
  assign hblank_rise = vid.fb_hblank & ~hblank_d;
  assign vblank_rise = vid.fb_vblank & ~vblank_d;

  // x_full/y_full mark that the last legal pixel/line was consumed; any
  // further active pixel before the next blank is a format error.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x           <= '0;
      y           <= '0;
      x_full      <= 1'b0;
      y_full      <= 1'b0;
      hblank_d    <= 1'b0;
      vblank_d    <= 1'b0;
      armed       <= 1'b0;
      active_mode <= 2'd0;
      active_rgb  <= '0;
      vid.frame_cnt <= 16'd0;
      vid.fmt_err   <= 1'b0;
    end else begin
      hblank_d <= vid.fb_hblank;
      vblank_d <= vid.fb_vblank;

      if (vid.fb_hblank) begin
        x      <= '0;
        x_full <= 1'b0;
      end else if (active) begin
        if (x == X_MAX) x_full <= 1'b1;
        else            x      <= x + 1'b1;
      end

      if (vid.fb_vblank) begin
        y      <= '0;
        y_full <= 1'b0;
      end else if (hblank_rise) begin
        if (y == Y_MAX) y_full <= 1'b1;
        else            y      <= y + 1'b1;
      end

      if (active && (x_full || y_full)) vid.fmt_err <= 1'b1;

      if (vblank_rise) begin
        active_mode   <= vid.mode;
        active_rgb    <= vid.solid_rgb;
        armed         <= 1'b1;
        vid.frame_cnt <= vid.frame_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    xw  = 32'(x);
    yw  = 32'(y);
    bar = 3'd0;
    pix = '0;
    for (int k = 1; k < 8; k++) begin
      if (xw >= BAR_T[k]) bar = 3'(k);
    end
    case (active_mode)
      2'd0: pix = {COLOR_W'(yw), COLOR_W'(xw), COLOR_W'(xw + yw)};
      // Bar order white..black is the binary count with R=~b1, G=~b2, B=~b0.
      2'd1: pix = {{COLOR_W{~bar[1]}}, {COLOR_W{~bar[2]}}, {COLOR_W{~bar[0]}}};
      2'd2: pix = (xw[CHECK_LOG2] ^ yw[CHECK_LOG2]) ? '0 : '1;
      default: pix = active_rgb;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vid.red         <= '0;
      vid.green       <= '0;
      vid.blue        <= '0;
      vid.frame_start <= 1'b0;
    end else begin
      if (active && armed) {vid.red, vid.green, vid.blue} <= pix;
      else                 {vid.red, vid.green, vid.blue} <= '0;
      vid.frame_start <= active && armed && (x == '0) && (y == '0);
    end
  end
endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: per-cycle scoreboard against a behavioural
// model, spec vector table, and hand sequences for the multi-cycle corners.
module tb_test_pattern_gen;
  localparam int CW = 8;
  localparam int HA = 640;
  localparam int VA = 480;
  localparam int CL = 3;
  localparam int W  = 3*CW + 18;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  test_pattern_gen_if #(.COLOR_W(CW)) vid();

  test_pattern_gen #(
    .COLOR_W(CW), .H_ACTIVE(HA), .V_ACTIVE(VA), .CHECK_LOG2(CL)
  ) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vid     (vid)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model state: unbounded pixel/line counts, saturated on use
  int              m_pix, m_lines, m_mode, m_cnt;
  bit              m_hprev, m_vprev, m_armed, m_first, m_err;
  logic [3*CW-1:0] m_rgb;
  logic [2:0]      bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                   3'b101, 3'b100, 3'b001, 3'b000};

  int              tgt_x = -1, tgt_y = -1, fs_seen = 0, frames_driven = 0;
  logic [3*CW-1:0] cap;

  typedef struct {
    logic [1:0]      mode;
    logic [3*CW-1:0] rgb;
    int              px;
    int              py;
    logic [3*CW-1:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3*CW-1:0] model_pix(int md, int px, int py, logic [3*CW-1:0] rgb);
    logic [3*CW-1:0] ones;
    logic [2:0]      b;
    int              bar;
    ones = '1;
    case (md)
      0: model_pix = {CW'(py), CW'(px), CW'(px + py)};
      1: begin
        bar = 0;
        for (int k = 0; k < 8; k++) if (px >= k*HA/8) bar = k;
        b = bar_tab[bar];
        model_pix = {{CW{b[2]}}, {CW{b[1]}}, {CW{b[0]}}};
      end
      2: model_pix = (((px >> CL) & 1) == ((py >> CL) & 1)) ? ones : '0;
      default: model_pix = rgb;
    endcase
  endfunction

  task automatic model_reset();
    m_pix = 0; m_lines = 0; m_mode = 0; m_cnt = 0; m_rgb = '0;
    m_hprev = 0; m_vprev = 0; m_armed = 0; m_first = 0; m_err = 0;
    frames_driven = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit hb, input bit vb, input int md, input logic [3*CW-1:0] rgb);
    bit act, fs;
    int ex, ey;
    logic [3*CW-1:0] pix;
    act = !hb && !vb;
    ex  = (m_pix < HA) ? m_pix : HA - 1;
    ey  = (m_lines < VA) ? m_lines : VA - 1;
    pix = (act && m_armed) ? model_pix(m_mode, ex, ey, m_rgb) : '0;
    fs  = act && m_armed && m_first;
    if (act && (m_pix >= HA || m_lines >= VA)) m_err = 1;
    if (act) m_first = 0;
    if (hb) m_pix = 0;
    else if (act) m_pix++;
    if (vb) m_lines = 0;
    else if (hb && !m_hprev) m_lines++;
    if (vb && !m_vprev) begin
      m_mode = md; m_rgb = rgb; m_armed = 1; m_first = 1;
      m_cnt = (m_cnt + 1) % 65536;
    end
    m_hprev = hb;
    m_vprev = vb;
    exp_q.push_back({pix, fs, 16'(m_cnt), m_err});
  endtask

  task automatic cyc(input bit hb, input bit vb);
    logic [W-1:0] a, e;
    vid.fb_hblank = hb;
    vid.fb_vblank = vb;
    @(posedge vga_clk);
    model_step(hb, vb, int'(vid.mode), vid.solid_rgb);
    #1;
    a = {vid.red, vid.green, vid.blue, vid.frame_start, vid.frame_cnt, vid.fmt_err};
    if (vid.frame_start) fs_seen++;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("cycle", 64'(a), 64'(e));
    end
  endtask

  task automatic vblank_period();
    frames_driven++;
    repeat (3) cyc(1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
  endtask

  task automatic line(input int npix, input int ly);
    for (int p = 0; p < npix; p++) begin
      cyc(1'b0, 1'b0);
      if (p == tgt_x && ly == tgt_y) cap = {vid.red, vid.green, vid.blue};
    end
    repeat (3) cyc(1'b1, 1'b0);
  endtask

  task automatic frame(input logic [1:0] md, input logic [3*CW-1:0] rgb, input int nl, input int np);
    vid.mode = md;
    vid.solid_rgb = rgb;
    vblank_period();
    for (int l = 0; l < nl; l++) line(np, l);
  endtask

  task automatic rand_frame();
    int nl, np;
    vid.mode = 2'($urandom_range(0, 3));
    vid.solid_rgb = 24'($urandom);
    vblank_period();
    nl = $urandom_range(1, 6);
    for (int l = 0; l < nl; l++) begin
      np = ($urandom_range(0, 7) == 0) ? HA : $urandom_range(1, 48);
      if ($urandom_range(0, 2) == 0) begin
        vid.mode = 2'($urandom_range(0, 3));
        vid.solid_rgb = 24'($urandom);
      end
      line(np, l);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 24'h0,      300, 10, 24'h0A2C36};
    vecs[1] = '{2'd1, 24'h0,       79,  0, 24'hFFFFFF};
    vecs[2] = '{2'd1, 24'h0,       80,  0, 24'hFFFF00};
    vecs[3] = '{2'd1, 24'h0,      639,  0, 24'h000000};
    vecs[4] = '{2'd2, 24'h0,        0,  0, 24'hFFFFFF};
    vecs[5] = '{2'd2, 24'h0,        8,  0, 24'h000000};
    vecs[6] = '{2'd2, 24'h0,        8,  8, 24'hFFFFFF};
    vecs[7] = '{2'd3, 24'h123456,   5,  3, 24'h123456};

    vid.fb_hblank = 1'b1;
    vid.fb_vblank = 1'b0;
    vid.mode = 2'd0;
    vid.solid_rgb = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset_state", 64'({vid.red, vid.green, vid.blue, vid.frame_start, vid.frame_cnt, vid.fmt_err}), 64'd0);
    reset_n = 1'b1;

    // before any vblank edge the output must stay black
    tgt_x = 4; tgt_y = 0;
    line(10, 0);
    check("pre_arm_black", 64'(cap), 64'd0);

    foreach (vecs[i]) begin
      tgt_x = vecs[i].px; tgt_y = vecs[i].py;
      frame(vecs[i].mode, vecs[i].rgb, vecs[i].py + 1, vecs[i].px + 1);
      check("vector_pixel", 64'(cap), 64'(vecs[i].exp));
    end

    // mode change mid-frame only takes effect at the next vblank
    vid.mode = 2'd0; vid.solid_rgb = '0;
    vblank_period();
    check("frame_cnt_step", 64'(vid.frame_cnt), 64'(frames_driven));
    tgt_x = -1;
    line(20, 0);
    vid.mode = 2'd3; vid.solid_rgb = 24'h123456;
    tgt_x = 5; tgt_y = 1;
    line(20, 1);
    check("mid_frame_gradient", 64'(cap), 64'h010506);
    line(20, 2);
    tgt_x = 7; tgt_y = 2;
    frame(2'd3, 24'h123456, 3, 20);
    check("next_frame_solid", 64'(cap), 64'h123456);
    check("frame_cnt_next", 64'(vid.frame_cnt), 64'(frames_driven));

    tgt_x = -1;
    for (int md = 0; md < 4; md++) begin
      fs_seen = 0;
      frame(2'(md), 24'($urandom), 2, 12);
      check("frame_start_once", 64'(fs_seen), 64'd1);
      cyc(1'b1, 1'b0);
      check("blank_black", 64'({vid.red, vid.green, vid.blue}), 64'd0);
    end

    repeat (24) rand_frame();

    // horizontal overflow: 641 active pixels on one line
    vid.mode = 2'd0;
    vblank_period();
    check("no_err_yet", 64'(vid.fmt_err), 64'd0);
    tgt_x = 640; tgt_y = 0;
    line(641, 0);
    check("x_saturated", 64'(cap), 64'h007F7F);
    check("x_overflow_err", 64'(vid.fmt_err), 64'd1);
    tgt_x = -1;
    line(5, 1);
    check("err_sticky", 64'(vid.fmt_err), 64'd1);

    // reset in the middle of a line clears everything at once
    repeat (3) cyc(1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_clear", 64'({vid.red, vid.green, vid.blue, vid.frame_start, vid.frame_cnt, vid.fmt_err}), 64'd0);
    repeat (2) @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    repeat (5) cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    tgt_x = 3; tgt_y = 1;
    frame(2'd0, '0, 2, 10);
    check("after_reset_pixel", 64'(cap), 64'h010304);
    check("cnt_after_reset", 64'(vid.frame_cnt), 64'd1);

    // vertical overflow: 480 lines are legal, the 481st is not
    tgt_x = -1;
    frame(2'd2, '0, VA, 1);
    check("y_full_ok", 64'(vid.fmt_err), 64'd0);
    line(1, VA);
    check("y_overflow_err", 64'(vid.fmt_err), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
